fadd_issue_ctrl: RTL and testbench
==================================

// Module: fadd_issue_ctrl
// PURPOSE
//  Front end for the 3-cycle fadd pipeline. Accepts FADD/FSUB ops on a valid/ready
//  port and drives fadd.adata/bdata, inverting the sign of B for FSUB. Tracks
//  in-flight ops with a valid/tag shift chain and captures fadd.result into an
//  output FIFO with valid/ready. A credit check stops fadd producing a result the FIFO cannot hold.
// PARAMETERS
//  TAG_W      5  width of the op tag carried alongside each op
//  LAT        3  fadd latency in clk edges; fixed by fadd, do not override
//  OUT_DEPTH  5  output FIFO entries; must be >= LAT+2 for 1 op/cycle throughput
// PORTS
//  clk        in   1      single clock; all state on posedge clk
//  rstn       in   1      asynchronous, active-low reset
//  in_valid   in   1      op offered
//  in_ready   out  1      op can be accepted this cycle
//  in_op      in   1      0 = add, 1 = sub (a - b)
//  in_a       in   32     operand A, IEEE-754 single
//  in_b       in   32     operand B, IEEE-754 single
//  in_tag     in   TAG_W  tag returned with the result
//  out_valid  out  1      result available at FIFO head
//  out_ready  in   1      consumer takes the head
//  out_data   out  32     result bits from fadd
//  out_tag    out  TAG_W  tag of the head entry
//  flush      in   1      only with FADD_ISSUE_FLUSH_EN; see CONFIGURATION
// BEHAVIOUR
//  - Accept = in_valid & in_ready. fadd.adata = in_a. fadd.bdata = {in_b[31]^in_op, in_b[30:0]}.
//    Both are driven combinationally every cycle; garbage on idle cycles is masked by v.
//  - v[LAT-1:0] and tag[LAT-1:0] form the shift chain:
//    - v[0] <= accept, tag[0] <= in_tag; v[i] <= v[i-1] each cycle.
//    - fadd.result belongs to the op whose v[LAT-1]=1, in that same cycle.
//  - FIFO write when v[LAT-1]=1: {result, tag[LAT-1]} is written at the edge.
//    - out_valid rises the next cycle. Accept at cycle N gives out_valid at N+LAT+1 (N+4).
//  - FIFO: circular, wr_ptr/rd_ptr wrap at OUT_DEPTH. count is 0..OUT_DEPTH.
//    - Pop = out_valid & out_ready.
//    - Simultaneous write and pop: count unchanged, both pointers advance.
//    - Popping when empty and writing when full never occur (guaranteed by credits).
//  - out_valid = (count != 0). out_data/out_tag are the head entry, read combinationally from FIFO storage.
//  - Credits: inflight = popcount(v).
//    - in_ready = (inflight + count) < OUT_DEPTH, combinational.
//    - A same-cycle pop is deliberately not counted.
//    - This bound guarantees every in-flight result has a FIFO slot; fadd is never stalled.
//  - Ordering: results leave strictly in accept order; no reordering or drop paths.
//  - Reset (rstn=0, async): v=0, pointers=0, count=0, FIFO storage cleared to 0.
//    - Outputs during and after reset: out_valid=0, out_data=0, out_tag=0, in_ready=1.
//    - Reset mid-operation discards all in-flight and buffered ops. fadd internal registers are
//      not reset; their stale results are ignored because v=0.
//  - Arithmetic: inflight + count uses a clog2(OUT_DEPTH+LAT+1)-bit sum; no overflow possible.
// CONFIGURATION
//  FADD_ISSUE_FLUSH_EN defined:
//   - flush port exists. flush=1 at an edge clears v, pointers and count.
//   - An op accepted in the flush cycle is also dropped.
//   - out_valid=0 in the next cycle; in_ready=1 in the next cycle. FIFO storage is not cleared.
//  FADD_ISSUE_FLUSH_EN undefined:
//   - flush port absent; the block behaves as if flush=0.
// TESTING
//  1 add: a=0x3F800000, b=0x40000000, op=0, tag=3, accept at cycle N
//    -> out_valid at N+4, out_data=0x40400000, out_tag=3.
//  2 sub: a=0x40400000, b=0x3F800000, op=1, tag=7 -> out_data=0x40000000, out_tag=7.
//  3 back-to-back: 16 adds on consecutive cycles, out_ready=1 -> in_ready stays 1,
//    16 results arrive on 16 consecutive cycles, tags in order.
//  4 backpressure: out_ready=0, 8 ops offered -> exactly 5 accepted, in_ready=0 after.
//    Raise out_ready -> 5 results in order, then the remaining 3 accepted.
//  5 reset: rstn low for 1 cycle while 3 ops are in flight -> out_valid=0, no stale result
//    ever appears, in_ready=1. A new op then completes with 4-cycle latency.
//  6 (FLUSH_EN) flush with 2 buffered and 2 in-flight -> out_valid=0 next cycle,
//    no result emerges for the 4 flushed ops, next op gets correct data and tag.

Source files
------------

// File: rtl/fadd_issue_ctrl.sv
// Issue front end for the 3-cycle single-precision adder: valid/ready op port, tag shift chain,
// credit-checked output FIFO. Optional flush port is enabled by defining FADD_ISSUE_FLUSH_EN.

module fadd (
    input  logic        clk,
    input  logic [31:0] adata,
    input  logic [31:0] bdata,
    output logic [31:0] result
);
    // Stage 1: order by magnitude, align the smaller mantissa with guard/round/sticky bits
    logic        a_big;
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  eb;
    logic [7:0]  es;
    logic [7:0]  eb_eff;
    logic [7:0]  es_eff;
    logic [23:0] mb;
    logic [23:0] ms;
    logic [7:0]  d;
    logic [49:0] ext;
    logic [26:0] sml27;
    logic [31:0] spec_val;

    assign a_big  = adata[30:0] >= bdata[30:0];
    assign big    = a_big ? adata : bdata;
    assign sml    = a_big ? bdata : adata;
    assign eb     = big[30:23];
    assign es     = sml[30:23];
    assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
    assign es_eff = (es == 8'd0) ? 8'd1 : es;
    assign mb     = {|eb, big[22:0]};
    assign ms     = {|es, sml[22:0]};
    assign d      = eb_eff - es_eff;

    always_comb begin
        ext = {ms, 26'b0} >> d;
        if (d > 8'd26) sml27 = {26'b0, |ms};
        else           sml27 = {ext[49:24], ext[23] | (|ext[22:0])};
        spec_val = big;
        if ((big[22:0] != 23'd0) || ((es == 8'hFF) && (big[31] != sml[31])))
            spec_val = 32'h7FC0_0000;
    end

    logic        s1_sign, s1_zero_sign, s1_sub, s1_spec;
    logic [7:0]  s1_exp;
    logic [26:0] s1_mb, s1_ms;
    logic [31:0] s1_spec_val;

    always_ff @(posedge clk) begin
        s1_sign      <= big[31];
        s1_zero_sign <= big[31] & sml[31];
        s1_sub       <= big[31] ^ sml[31];
        s1_spec      <= (eb == 8'hFF);
        s1_spec_val  <= spec_val;
        s1_exp       <= eb_eff;
        s1_mb        <= {mb, 3'b0};
        s1_ms        <= sml27;
    end

    // Stage 2: add/subtract and normalise, stopping at the denormal boundary
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [8:0]  lim;
    logic [8:0]  sh;
    logic [26:0] n_m;
    logic [8:0]  n_e;

    always_comb begin
        sum = s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms}) : ({1'b0, s1_mb} + {1'b0, s1_ms});
        lz  = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        lim = {1'b0, s1_exp} - 9'd1;
        sh  = ({4'b0, lz} < lim) ? {4'b0, lz} : lim;
        if (sum[27]) begin
            n_m = {sum[27:2], sum[1] | sum[0]};
            n_e = {1'b0, s1_exp} + 9'd1;
        end else begin
            n_m = sum[26:0] << sh;
            n_e = {1'b0, s1_exp} - sh;
            if (!n_m[26]) n_e = 9'd0;
        end
    end

    logic        s2_sign, s2_spec;
    logic [8:0]  s2_exp;
    logic [26:0] s2_m;
    logic [31:0] s2_spec_val;

    always_ff @(posedge clk) begin
        s2_sign     <= (sum == 28'd0) ? s1_zero_sign : s1_sign;
        s2_spec     <= s1_spec;
        s2_spec_val <= s1_spec_val;
        s2_exp      <= n_e;
        s2_m        <= n_m;
    end

    // Stage 3: round to nearest even, pack, saturate to infinity
    logic        rnd;
    logic [24:0] mr;
    logic [8:0]  e9;
    logic [22:0] frac;
    logic [31:0] res_d;

    always_comb begin
        rnd = s2_m[2] & (s2_m[1] | s2_m[0] | s2_m[3]);
        mr  = {1'b0, s2_m[26:3]} + {24'b0, rnd};
        e9  = s2_exp + {8'b0, mr[24]};
        if (!mr[24] && (s2_exp == 9'd0) && mr[23]) e9 = 9'd1;
        frac = mr[24] ? mr[23:1] : mr[22:0];
        if (s2_spec)             res_d = s2_spec_val;
        else if (e9 >= 9'd255)   res_d = {s2_sign, 8'hFF, 23'b0};
        else                     res_d = {s2_sign, e9[7:0], frac};
    end

    always_ff @(posedge clk) begin
        result <= res_d;
    end
endmodule

module fadd_issue_ctrl #(
    parameter int TAG_W     = 5,
    parameter int LAT       = 3,
    parameter int OUT_DEPTH = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef FADD_ISSUE_FLUSH_EN
    ,
    input  logic             flush
`endif
);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int SUM_W = $clog2(OUT_DEPTH + LAT + 1);

    // Handshake: a transfer happens on any clk edge where valid and ready are both high;
    // ready never depends on valid on the same port, and an offered op stays until taken.
    logic             accept;
    logic             pop;
    logic             wr;
    logic             do_flush;
    logic [LAT-1:0]   v;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      mem_data [OUT_DEPTH];
    logic [TAG_W-1:0] mem_tag  [OUT_DEPTH];
    logic [SUM_W-1:0] inflight;
    logic [31:0]      fadd_result;
    logic [31:0]      bdata;

`ifdef FADD_ISSUE_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign bdata = {in_b[31] ^ in_op, in_b[30:0]};

    fadd u_fadd (
        .clk    (clk),
        .adata  (in_a),
        .bdata  (bdata),
        .result (fadd_result)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + SUM_W'(v[i]);
    end

    // A pop in the same cycle is not credited; keeps in_ready free of out_ready.
    assign in_ready  = (inflight + SUM_W'(count)) < SUM_W'(OUT_DEPTH);
    assign accept    = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign wr        = v[LAT-1];
    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v      <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else begin
            tag_q[0] <= in_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            if (wr) begin
                mem_data[wr_ptr] <= fadd_result;
                mem_tag[wr_ptr]  <= tag_q[LAT-1];
            end
            if (do_flush) begin
                v      <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                v <= {v[LAT-2:0], accept};
                if (wr)
                    wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                case ({wr, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Directed bench for fadd_issue_ctrl: driver tasks push expected results, a negedge monitor pops
// and compares data, tag and (where requested) arrival cycle.

module tb_fadd_issue_ctrl;
  localparam int TAG_W = 5;
  localparam int EXP_W = 32 + TAG_W + 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef FADD_ISSUE_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EXP_W-1:0] exp_q[$];

  fadd_issue_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef FADD_ISSUE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%0h tag %0d, expected no output", out_data, out_tag);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e[EXP_W-1 -: 32]));
        check("out_tag", 64'(out_tag), 64'(e[31+TAG_W:32]));
        if (e[31:0] != 32'd0) check("latency_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
  end

  // driver tasks; all return 1 time unit after a posedge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                       input bit expect_out, input bit chk_lat, input int budget,
                       output bit ok);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    ok       = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (expect_out)
          exp_q.push_back({exp_data, tag, chk_lat ? 32'(cyc + 4) : 32'd0});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // op, a, b, tag, expected result
  logic [31:0] vec_a [6] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40000000, 32'h41200000, 32'h3F800001};
  logic [31:0] vec_b [6] = '{32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h3E800000, 32'h33800000};
  logic        vec_op[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [4:0]  vec_t [6] = '{5'd3, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12};
  logic [31:0] vec_r [6] = '{32'h40400000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h41240000, 32'h3F800002};

  initial begin
    bit ok;
    int accepted;
    logic [31:0] a;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_op = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;
`ifdef FADD_ISSUE_FLUSH_EN
    flush = 1'b0;
`endif
    idle(2);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rstn = 1'b1;
    idle(2);

    // directed arithmetic vectors, one at a time, latency checked
    for (int i = 0; i < 6; i++) begin
      offer(vec_op[i], vec_a[i], vec_b[i], vec_t[i], vec_r[i], 1'b1, 1'b1, 4, ok);
      check("single_accept", 64'(ok), 64'd1);
      idle(5);
    end
    check("1_plus_neg_half", 64'(exp_q.size()), 64'd0);
    offer(1'b0, 32'h3F800000, 32'hBF000000, 5'd13, 32'h3F000000, 1'b1, 1'b1, 4, ok);
    offer(1'b1, 32'h3F800000, 32'hBF800000, 5'd14, 32'h40000000, 1'b1, 1'b1, 4, ok);
    drain(20);

    // back-to-back: x + 0 returns x
    for (int i = 0; i < 16; i++) begin
      a = {1'b0, 8'(120 + i), 23'(i * 37)};
      offer(1'b0, a, 32'h0, 5'(i), a, 1'b1, 1'b1, 1, ok);
      check("b2b_in_ready", 64'(ok), 64'd1);
    end
    drain(20);

    // backpressure: five credits only
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      a = {1'b0, 8'd130, 23'(i)};
      offer(1'b0, a, 32'h0, 5'(16 + i), a, 1'b1, 1'b0, 4, ok);
      if (!ok) break;
      accepted++;
    end
    check("bp_accepted", 64'(accepted), 64'd5);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = accepted; i < 8; i++) begin
      a = {1'b0, 8'd130, 23'(i)};
      offer(1'b0, a, 32'h0, 5'(16 + i), a, 1'b1, 1'b0, 20, ok);
      check("bp_late_accept", 64'(ok), 64'd1);
    end
    drain(30);

    // reset with three ops in flight
    for (int i = 0; i < 3; i++)
      offer(1'b0, 32'h3F800000, 32'h3F800000, 5'(24 + i), 32'h0, 1'b0, 1'b0, 1, ok);
    rstn = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(8);
    check("rst_after_out_valid", 64'(out_valid), 64'd0);
    check("rst_after_in_ready", 64'(in_ready), 64'd1);
    offer(1'b0, 32'h3F800000, 32'h40000000, 5'd30, 32'h40400000, 1'b1, 1'b1, 2, ok);
    check("rst_new_accept", 64'(ok), 64'd1);
    drain(20);

`ifdef FADD_ISSUE_FLUSH_EN
    // flush with two buffered and two in flight, plus an op offered in the flush cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      offer(1'b0, 32'h40000000, 32'h40000000, 5'(i), 32'h0, 1'b0, 1'b0, 1, ok);
    idle(1);
    check("pre_flush_out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    offer(1'b0, 32'h40000000, 32'h40000000, 5'd4, 32'h0, 1'b0, 1'b0, 1, ok);
    flush = 1'b0;
    check("flush_cycle_accept", 64'(ok), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    idle(8);
    offer(1'b1, 32'h40400000, 32'h3F800000, 5'd21, 32'h40000000, 1'b1, 1'b1, 2, ok);
    check("flush_new_accept", 64'(ok), 64'd1);
    drain(20);
`endif

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
